// File: rtl/motoro3_commutator_ramp.sv
// motoro3_commutator_ramp: six-step BLDC commutation sequencer with
// soft-start period ramp, direction, brake, dead-time and rev counter.
// Ports:
//   clk, nRst            clock (regs on falling edge), async reset (low)
//   m3start/m3dir/m3brake run level, 0=fwd 1=rev, brake (wins over run)
//   period_init/target   start and final step period in clk cycles
//   aE..cE, aH1_L0..cH1_L0 registered phase enables / high-low selects
//   m3step, m3cnt        0 idle, 1..6 run, 7 brake; cycles left in step
//   cur_period, ramp_done period of this step; at target while running
//   dead, round_cnt      blanking active; completed revolutions
module motoro3_commutator_ramp #(
  parameter int CNT_W    = 25,
  parameter int RCNT_W   = 32,
  parameter int RAMP_DEC = 64,
  parameter int DEAD_CYC = 4
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              m3start,
  input  logic              m3dir,
  input  logic              m3brake,
  input  logic [CNT_W-1:0]  period_init,
  input  logic [CNT_W-1:0]  period_target,
  output logic              aE,
  output logic              bE,
  output logic              cE,
  output logic              aH1_L0,
  output logic              bH1_L0,
  output logic              cH1_L0,
  output logic [3:0]        m3step,
  output logic [CNT_W-1:0]  m3cnt,
  output logic [CNT_W-1:0]  cur_period,
  output logic              ramp_done,
  output logic              dead,
  output logic [RCNT_W-1:0] round_cnt
);

  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [DW-1:0]    DEAD_LD = DW'(DEAD_CYC);
  localparam logic [CNT_W-1:0] RDEC    = CNT_W'(RAMP_DEC);
  localparam logic [CNT_W-1:0] PMIN    = CNT_W'(2);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S1     = 4'd1,
    S2     = 4'd2,
    S3     = 4'd3,
    S4     = 4'd4,
    S5     = 4'd5,
    S6     = 4'd6,
    S_BRK  = 4'd7
  } step_e;

  step_e             step_q, step_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  per_q, per_d;
  logic [RCNT_W-1:0] round_q, round_d;
  logic [DW-1:0]     dead_q, dead_d;
  logic              start_q;
  logic              ramp_q, ramp_d;
  logic [2:0]        e_q, e_d;
  logic [2:0]        h_q, h_d;

  logic [CNT_W-1:0]  pinit;
  logic [CNT_W-1:0]  ptgt;
  logic [CNT_W-1:0]  new_per;
  logic              start_up;
  logic              running;
  logic              bnd;
  logic              wrap;
  step_e             nxt;
  logic [5:0]        eh;

  // Returns {E[a,b,c], H[a,b,c]} for a step.
  function automatic logic [5:0] decode(input step_e s);
    logic [5:0] r;
    r = 6'b000_000;
    unique case (s)
      S1:      r = 6'b101_100;
      S2:      r = 6'b011_010;
      S3:      r = 6'b110_010;
      S4:      r = 6'b101_001;
      S5:      r = 6'b011_001;
      S6:      r = 6'b110_100;
      S_BRK:   r = 6'b111_000;
      default: r = 6'b000_000;
    endcase
    return r;
  endfunction

  function automatic step_e next_step(input step_e s, input logic rev);
    step_e r;
    r = S_IDLE;
    unique case (s)
      S1:      r = rev ? S6 : S2;
      S2:      r = rev ? S1 : S3;
      S3:      r = rev ? S2 : S4;
      S4:      r = rev ? S3 : S5;
      S5:      r = rev ? S4 : S6;
      S6:      r = rev ? S5 : S1;
      default: r = S_IDLE;
    endcase
    return r;
  endfunction

  always_comb begin
    pinit = (period_init < PMIN) ? PMIN : period_init;
    ptgt  = (period_target < PMIN) ? PMIN : period_target;
  end

  assign start_up = m3start & ~start_q & ~m3brake;
  assign running  = (step_q >= S1) && (step_q <= S6);
  assign bnd      = (cnt_q <= CNT_W'(1));
  assign nxt      = next_step(step_q, m3dir);
  assign wrap     = m3dir ? (step_q == S1) : (step_q == S6);

  // Move toward the target by at most RAMP_DEC; differences are
  // compared before adding so the sum never overshoots or overflows.
  always_comb begin
    new_per = per_q;
    if (per_q > ptgt) begin
      new_per = ((per_q - ptgt) > RDEC) ? per_q - RDEC : ptgt;
    end else if (per_q < ptgt) begin
      new_per = ((ptgt - per_q) > RDEC) ? per_q + RDEC : ptgt;
    end
  end

  always_comb begin
    step_d  = step_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    round_d = round_q;
    dead_d  = (dead_q != '0) ? dead_q - DW'(1) : '0;
    if (m3brake) begin
      step_d = S_BRK;
      cnt_d  = pinit;
      dead_d = '0;
    end else if (!m3start) begin
      step_d  = S_IDLE;
      cnt_d   = pinit;
      per_d   = pinit;
      round_d = '0;
      dead_d  = '0;
    end else if (start_up || step_q == S_BRK) begin
      step_d  = m3dir ? S6 : S1;
      cnt_d   = pinit;
      per_d   = pinit;
      round_d = '0;
      dead_d  = DEAD_LD;
    end else if (running && bnd) begin
      step_d = nxt;
      cnt_d  = new_per;
      per_d  = new_per;
      dead_d = DEAD_LD;
      if (wrap) begin
        round_d = round_q + RCNT_W'(1);
      end
    end else if (running) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Phase outputs follow the next step so they change with m3step;
  // enables stay low while the blanking counter is still nonzero.
  always_comb begin
    eh     = decode(step_d);
    h_d    = eh[2:0];
    e_d    = (dead_d != '0) ? 3'b000 : eh[5:3];
    ramp_d = (step_d >= S1) && (step_d <= S6) && (per_d == ptgt);
  end

  always_ff @(negedge clk or negedge nRst) begin
    if (!nRst) begin
      step_q  <= S_IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      round_q <= '0;
      dead_q  <= '0;
      start_q <= 1'b0;
      ramp_q  <= 1'b0;
      e_q     <= 3'b000;
      h_q     <= 3'b000;
    end else begin
      step_q  <= step_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      round_q <= round_d;
      dead_q  <= dead_d;
      start_q <= m3start;
      ramp_q  <= ramp_d;
      e_q     <= e_d;
      h_q     <= h_d;
    end
  end

  assign aE         = e_q[2];
  assign bE         = e_q[1];
  assign cE         = e_q[0];
  assign aH1_L0     = h_q[2];
  assign bH1_L0     = h_q[1];
  assign cH1_L0     = h_q[0];
  assign m3step     = step_q;
  assign m3cnt      = cnt_q;
  assign cur_period = per_q;
  assign ramp_done  = ramp_q;
  assign dead       = (dead_q != '0);
  assign round_cnt  = round_q;

endmodule

// File: tb/tb_motoro3_commutator_ramp.sv
// tb_motoro3_commutator_ramp: directed scenarios for the commutator;
// a monitor checks each step change against a queue of expected records.
module tb_motoro3_commutator_ramp;

  localparam int CW = 25;
  localparam int RW = 32;

  logic          clk;
  logic          nRst;
  logic          m3start;
  logic          m3dir;
  logic          m3brake;
  logic [CW-1:0] period_init;
  logic [CW-1:0] period_target;
  logic          aE, bE, cE;
  logic          aH1_L0, bH1_L0, cH1_L0;
  logic [3:0]    m3step;
  logic [CW-1:0] m3cnt;
  logic [CW-1:0] cur_period;
  logic          ramp_done;
  logic          dead;
  logic [RW-1:0] round_cnt;

  motoro3_commutator_ramp #(
    .CNT_W(CW),
    .RCNT_W(RW),
    .RAMP_DEC(100),
    .DEAD_CYC(2)
  ) dut (
    .clk(clk),
    .nRst(nRst),
    .m3start(m3start),
    .m3dir(m3dir),
    .m3brake(m3brake),
    .period_init(period_init),
    .period_target(period_target),
    .aE(aE),
    .bE(bE),
    .cE(cE),
    .aH1_L0(aH1_L0),
    .bH1_L0(bH1_L0),
    .cH1_L0(cH1_L0),
    .m3step(m3step),
    .m3cnt(m3cnt),
    .cur_period(cur_period),
    .ramp_done(ramp_done),
    .dead(dead),
    .round_cnt(round_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  typedef struct {
    logic [3:0] st;
    int         per;
    logic [2:0] en;
    logic [2:0] ea;
    logic [2:0] h;
    int         rnd;
    logic       rd;
    logic       dd;
    int         len;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] st, input int per,
                      input logic [2:0] en, input logic [2:0] ea,
                      input logic [2:0] h, input int rnd,
                      input logic rd, input logic dd, input int len);
    exp_t e;
    e.st = st; e.per = per; e.en = en; e.ea = ea; e.h = h;
    e.rnd = rnd; e.rd = rd; e.dd = dd; e.len = len;
    q.push_back(e);
  endtask

  // Monitor: a change of m3step is the DUT's "output event".
  logic [3:0] prev_st = 4'd0;
  int         cyc = 0;
  bit         have = 1'b0;
  exp_t       cur;

  always @(posedge clk) begin
    cyc++;
    if (m3step != prev_st) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_step: got %0d, expected none",
                 m3step);
      end else begin
        cur = q.pop_front();
        have = 1'b1;
        chk("step", 64'(m3step), 64'(cur.st));
        chk("period", 64'(cur_period), 64'(cur.per));
        chk("cnt_load", 64'(m3cnt), 64'(cur.per));
        chk("E_edge", 64'({aE, bE, cE}), 64'(cur.en));
        chk("H", 64'({aH1_L0, bH1_L0, cH1_L0}), 64'(cur.h));
        chk("round", 64'(round_cnt), 64'(cur.rnd));
        chk("ramp_done", 64'(ramp_done), 64'(cur.rd));
        chk("dead_edge", 64'(dead), 64'(cur.dd));
        if (cur.len != 0) chk("step_len", 64'(cyc), 64'(cur.len));
      end
      cyc = 0;
      prev_st = m3step;
    end else if (have && cyc == 2) begin
      chk("E_after", 64'({aE, bE, cE}), 64'(cur.ea));
      chk("dead_after", 64'(dead), 64'd0);
    end
  end

  task automatic wait_enter(input logic [3:0] s, input int budget,
                            input string nm);
    logic [3:0] p;
    int n;
    bit ok;
    p = m3step;
    n = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(posedge clk);
      n++;
      if (m3step == s && p != s) ok = 1'b1;
      p = m3step;
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL timeout_%s: got step %0d, expected %0d",
               nm, m3step, s);
    end
  endtask

  initial begin
    nRst = 1'b1;
    m3start = 1'b0;
    m3dir = 1'b0;
    m3brake = 1'b0;
    period_init = '0;
    period_target = '0;
    #2 nRst = 1'b0;
    #20;
    chk("rst_step", 64'(m3step), 64'd0);
    chk("rst_outs", 64'({aE, bE, cE, aH1_L0, bH1_L0, cH1_L0}), 64'd0);
    chk("rst_cnt", 64'(m3cnt), 64'd0);
    chk("rst_round", 64'(round_cnt), 64'd0);
    repeat (3) @(posedge clk);
    nRst = 1'b1;
    repeat (5) @(posedge clk);

    // Ramp down 1000 -> 700, then target change to 500 mid-step.
    push(1, 1000, 3'b000, 3'b101, 3'b100, 0, 0, 1, 0);
    push(2, 900, 3'b000, 3'b011, 3'b010, 0, 0, 1, 1000);
    push(3, 800, 3'b000, 3'b110, 3'b010, 0, 0, 1, 900);
    push(4, 700, 3'b000, 3'b101, 3'b001, 0, 1, 1, 800);
    push(5, 700, 3'b000, 3'b011, 3'b001, 0, 1, 1, 700);
    push(6, 700, 3'b000, 3'b110, 3'b100, 0, 1, 1, 700);
    push(1, 700, 3'b000, 3'b101, 3'b100, 1, 1, 1, 700);
    push(2, 600, 3'b000, 3'b011, 3'b010, 1, 0, 1, 700);
    push(3, 500, 3'b000, 3'b110, 3'b010, 1, 1, 1, 600);
    push(0, 1000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    period_init = 25'd1000;
    period_target = 25'd700;
    m3dir = 1'b0;
    m3start = 1'b1;
    wait_enter(1, 10, "A_start");
    wait_enter(1, 8000, "A_wrap");
    repeat (100) @(posedge clk);
    period_target = 25'd500;
    wait_enter(3, 2000, "A_s3");
    repeat (50) @(posedge clk);
    m3start = 1'b0;
    wait_enter(0, 10, "A_stop");
    repeat (5) @(posedge clk);

    // Reverse, direction change in step 4, brake, restart.
    push(6, 300, 3'b000, 3'b110, 3'b100, 0, 1, 1, 0);
    push(5, 300, 3'b000, 3'b011, 3'b001, 0, 1, 1, 300);
    push(4, 300, 3'b000, 3'b101, 3'b001, 0, 1, 1, 300);
    push(3, 300, 3'b000, 3'b110, 3'b010, 0, 1, 1, 300);
    push(2, 300, 3'b000, 3'b011, 3'b010, 0, 1, 1, 300);
    push(1, 300, 3'b000, 3'b101, 3'b100, 0, 1, 1, 300);
    push(6, 300, 3'b000, 3'b110, 3'b100, 1, 1, 1, 300);
    push(5, 300, 3'b000, 3'b011, 3'b001, 1, 1, 1, 300);
    push(4, 300, 3'b000, 3'b101, 3'b001, 1, 1, 1, 300);
    push(5, 300, 3'b000, 3'b011, 3'b001, 1, 1, 1, 300);
    push(6, 300, 3'b000, 3'b110, 3'b100, 1, 1, 1, 300);
    push(1, 300, 3'b000, 3'b101, 3'b100, 2, 1, 1, 300);
    push(2, 300, 3'b000, 3'b011, 3'b010, 2, 1, 1, 300);
    push(7, 300, 3'b111, 3'b111, 3'b000, 2, 0, 0, 0);
    push(1, 300, 3'b000, 3'b101, 3'b100, 0, 1, 1, 0);
    push(0, 300, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    period_init = 25'd300;
    period_target = 25'd300;
    m3dir = 1'b1;
    m3start = 1'b1;
    wait_enter(4, 1500, "B_s4a");
    wait_enter(4, 3000, "B_s4b");
    repeat (100) @(posedge clk);
    m3dir = 1'b0;
    wait_enter(2, 2000, "B_s2");
    repeat (50) @(posedge clk);
    m3brake = 1'b1;
    wait_enter(7, 5, "B_brake");
    repeat (10) @(posedge clk);
    m3brake = 1'b0;
    wait_enter(1, 5, "B_restart");
    repeat (50) @(posedge clk);
    m3start = 1'b0;
    wait_enter(0, 5, "B_stop");
    repeat (5) @(posedge clk);

    // Ramp up from a clamped init of 1.
    push(1, 2, 3'b000, 3'b101, 3'b100, 0, 0, 1, 0);
    push(2, 102, 3'b000, 3'b011, 3'b010, 0, 0, 1, 2);
    push(3, 202, 3'b000, 3'b110, 3'b010, 0, 0, 1, 102);
    push(4, 300, 3'b000, 3'b101, 3'b001, 0, 1, 1, 202);
    push(5, 300, 3'b000, 3'b011, 3'b001, 0, 1, 1, 300);
    push(0, 2, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    period_init = 25'd1;
    period_target = 25'd300;
    m3start = 1'b1;
    wait_enter(5, 2000, "C_s5");
    repeat (20) @(posedge clk);
    m3start = 1'b0;
    wait_enter(0, 5, "C_stop");
    repeat (5) @(posedge clk);

    // Asynchronous reset in the middle of step 3.
    push(1, 300, 3'b000, 3'b101, 3'b100, 0, 1, 1, 0);
    push(2, 300, 3'b000, 3'b011, 3'b010, 0, 1, 1, 300);
    push(3, 300, 3'b000, 3'b110, 3'b010, 0, 1, 1, 300);
    push(0, 0, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0);
    period_init = 25'd300;
    m3start = 1'b1;
    wait_enter(3, 1500, "D_s3");
    repeat (50) @(posedge clk);
    #3 nRst = 1'b0;
    m3start = 1'b0;
    #1;
    chk("arst_step", 64'(m3step), 64'd0);
    chk("arst_outs", 64'({aE, bE, cE, aH1_L0, bH1_L0, cH1_L0}), 64'd0);
    chk("arst_cnt", 64'(m3cnt), 64'd0);
    chk("arst_per", 64'(cur_period), 64'd0);
    chk("arst_misc", 64'({ramp_done, dead}), 64'd0);
    repeat (3) @(posedge clk);
    nRst = 1'b1;
    repeat (20) @(posedge clk);
    chk("post_rst_step", 64'(m3step), 64'd0);
    chk("post_rst_E", 64'({aE, bE, cE}), 64'd0);
    chk("post_rst_round", 64'(round_cnt), 64'd0);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
